// File: rtl/flash_spi_master_if.sv
// Firmware-side bus of flash_spi_master: command strobe, write FIFO push port,
// read FIFO pop port and busy status.
interface flash_spi_master_if;
  logic [7:0] instruction;
  logic       execute;
  logic [7:0] bytes_to_read;
  logic [7:0] write_buffer_data;
  logic       write_buffer_write;
  logic       write_buffer_full;
  logic       read_buffer_read;
  logic [7:0] read_buffer_q;
  logic       read_buffer_empty;
  logic       busy;

  modport master (
    output instruction, execute, bytes_to_read,
    output write_buffer_data, write_buffer_write, read_buffer_read,
    input  write_buffer_full, read_buffer_q, read_buffer_empty, busy
  );

  modport slave (
    input  instruction, execute, bytes_to_read,
    input  write_buffer_data, write_buffer_write, read_buffer_read,
    output write_buffer_full, read_buffer_q, read_buffer_empty, busy
  );
endinterface

// File: rtl/flash_spi_master.sv
// SPI mode-0 command engine for the serial NOR flash: instruction, queued write bytes, then reads.
// Optional FLASH_POLL_EN: auto-poll Read Flag Status (0x70) after program/erase opcodes.
module flash_spi_master #(
  parameter int unsigned CLK_DIV         = 2,
  parameter int unsigned WBUF_DEPTH_LOG2 = 8,
  parameter int unsigned RBUF_DEPTH_LOG2 = 4,
  parameter int unsigned CS_HIGH_CYCLES  = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  flash_spi_master_if.slave  bus,
  output logic               flash_c,
  output logic               flash_sb,
  inout  wire  [3:0]         flash_dq
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GAP_W  = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;
  localparam int unsigned WPTR_W = WBUF_DEPTH_LOG2 + 1;
  localparam int unsigned RPTR_W = RBUF_DEPTH_LOG2 + 1;
  localparam int unsigned WDEPTH = 1 << WBUF_DEPTH_LOG2;
  localparam int unsigned RDEPTH = 1 << RBUF_DEPTH_LOG2;

  typedef enum logic [2:0] {
    S_IDLE, S_CS_SETUP, S_INSTR, S_WRITE, S_READ, S_CS_HOLD, S_CS_GAP
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               sclk_q, sclk_d;
  logic               sb_q, sb_d;
  logic               mosi_q, mosi_d;
  logic               busy_q, busy_d;
  logic [7:0]         tx_q, tx_d;
  logic [7:0]         rx_q, rx_d;
  logic [7:0]         rd_left_q, rd_left_d;
  logic [2:0]         bit_q, bit_d;
`ifdef FLASH_POLL_EN
  logic [7:0]         instr_q, instr_d;
  logic               poll_q, poll_d;
`endif

  logic [7:0]         wmem [WDEPTH];
  logic [7:0]         rmem [RDEPTH];
  logic [WPTR_W-1:0]  wwr_q, wrd_q;
  logic [RPTR_W-1:0]  rwr_q, rrd_q;
  logic               wempty, wfull, rempty, rfull;
  logic               w_push, w_pop, r_push, r_pop;
  logic [7:0]         whead;
  logic               tick, stall, miso, poll_act;

  // Pin map: MOSI on DQ0, MISO on DQ1, W# and HOLD# held inactive
  assign flash_dq[0] = mosi_q;
  assign flash_dq[1] = 1'bz;
  assign flash_dq[2] = 1'b1;
  assign flash_dq[3] = 1'b1;
  assign miso        = flash_dq[1];
  assign flash_c     = sclk_q;
  assign flash_sb    = sb_q;
  assign bus.busy    = busy_q;

  // Write and read FIFOs: extra pointer bit separates full from empty
  assign wempty = (wwr_q == wrd_q);
  assign wfull  = (wwr_q[WBUF_DEPTH_LOG2] != wrd_q[WBUF_DEPTH_LOG2]) &&
                  (wwr_q[WBUF_DEPTH_LOG2-1:0] == wrd_q[WBUF_DEPTH_LOG2-1:0]);
  assign rempty = (rwr_q == rrd_q);
  assign rfull  = (rwr_q[RBUF_DEPTH_LOG2] != rrd_q[RBUF_DEPTH_LOG2]) &&
                  (rwr_q[RBUF_DEPTH_LOG2-1:0] == rrd_q[RBUF_DEPTH_LOG2-1:0]);
  assign w_push = bus.write_buffer_write && !wfull;
  assign r_pop  = bus.read_buffer_read && !rempty;
  assign whead  = wmem[wrd_q[WBUF_DEPTH_LOG2-1:0]];

  assign bus.write_buffer_full = wfull;
  assign bus.read_buffer_empty = rempty;
  assign bus.read_buffer_q     = rmem[rrd_q[RBUF_DEPTH_LOG2-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wwr_q <= '0;
      wrd_q <= '0;
      rwr_q <= '0;
      rrd_q <= '0;
    end else begin
      if (w_push) wwr_q <= wwr_q + WPTR_W'(1);
      if (w_pop)  wrd_q <= wrd_q + WPTR_W'(1);
      if (r_push) rwr_q <= rwr_q + RPTR_W'(1);
      if (r_pop)  rrd_q <= rrd_q + RPTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) wmem[wwr_q[WBUF_DEPTH_LOG2-1:0]] <= bus.write_buffer_data;
    if (r_push) rmem[rwr_q[RBUF_DEPTH_LOG2-1:0]] <= rx_q;
  end

`ifdef FLASH_POLL_EN
  assign poll_act = poll_q;
`else
  assign poll_act = 1'b0;
`endif

  assign tick  = (div_q == DIV_W'(CLK_DIV - 1));
  // Hold flash_c low at a read byte boundary until the read FIFO has room
  assign stall = (state_q == S_READ) && (bit_q == 3'd0) && rfull && !poll_act;

  always_comb begin
    state_d   = state_q;
    div_d     = '0;
    gap_d     = '0;
    sclk_d    = sclk_q;
    sb_d      = sb_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rd_left_d = rd_left_q;
    bit_d     = bit_q;
    w_pop     = 1'b0;
    r_push    = 1'b0;
`ifdef FLASH_POLL_EN
    instr_d   = instr_q;
    poll_d    = poll_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.execute) begin
          state_d   = S_CS_SETUP;
          busy_d    = 1'b1;
          sb_d      = 1'b0;
          sclk_d    = 1'b0;
          tx_d      = bus.instruction;
          mosi_d    = bus.instruction[7];
          rd_left_d = bus.bytes_to_read;
          bit_d     = 3'd0;
`ifdef FLASH_POLL_EN
          instr_d   = bus.instruction;
`endif
        end
      end
      S_CS_SETUP: begin
        if (tick) begin
          sclk_d  = 1'b1;
          rx_d    = {rx_q[6:0], miso};
          state_d = S_INSTR;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_INSTR, S_WRITE, S_READ: begin
        if (!tick) begin
          div_d = div_q + DIV_W'(1);
        end else if (!sclk_q) begin
          if (stall) begin
            div_d = div_q;
          end else begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[6:0], miso};
          end
        end else begin
          // Falling edge: present the next MOSI bit while flash_c is low
          sclk_d = 1'b0;
          bit_d  = bit_q + 3'd1;
          tx_d   = {tx_q[6:0], 1'b0};
          mosi_d = tx_q[6];
          if (bit_q == 3'd7) begin
            if (state_q == S_READ) begin
              r_push    = !poll_act;
              rd_left_d = rd_left_q - 8'd1;
            end
            if (state_q != S_READ && !wempty && !poll_act) begin
              w_pop   = 1'b1;
              tx_d    = whead;
              mosi_d  = whead[7];
              state_d = S_WRITE;
            end else if (rd_left_d != 8'd0) begin
              tx_d    = '0;
              mosi_d  = 1'b0;
              state_d = S_READ;
            end else begin
              mosi_d  = 1'b0;
              state_d = S_CS_HOLD;
            end
          end
        end
      end
      S_CS_HOLD: begin
        if (tick) begin
          sb_d    = 1'b1;
          state_d = S_CS_GAP;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_CS_GAP: begin
        gap_d = gap_q + GAP_W'(1);
        if (gap_q == GAP_W'(CS_HIGH_CYCLES - 1)) begin
          gap_d = '0;
`ifdef FLASH_POLL_EN
          // Poll flag status after program/erase until the ready bit is set
          if (poll_q ? !rx_q[7] :
              (instr_q == 8'h02 || instr_q == 8'h20 || instr_q == 8'hD8)) begin
            state_d   = S_CS_SETUP;
            sb_d      = 1'b0;
            instr_d   = 8'h70;
            tx_d      = 8'h70;
            mosi_d    = 1'b0;
            rd_left_d = 8'd1;
            bit_d     = 3'd0;
            poll_d    = 1'b1;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            poll_d  = 1'b0;
          end
`else
          state_d = S_IDLE;
          busy_d  = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      gap_q     <= '0;
      sclk_q    <= 1'b0;
      sb_q      <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      rd_left_q <= '0;
      bit_q     <= '0;
`ifdef FLASH_POLL_EN
      instr_q   <= '0;
      poll_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      gap_q     <= gap_d;
      sclk_q    <= sclk_d;
      sb_q      <= sb_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rd_left_q <= rd_left_d;
      bit_q     <= bit_d;
`ifdef FLASH_POLL_EN
      instr_q   <= instr_d;
      poll_q    <= poll_d;
`endif
    end
  end

endmodule

// File: tb/tb_flash_spi_master.sv
// Scoreboard bench for flash_spi_master with a behavioural serial-flash model on the pins.
module tb_flash_spi_master;
  localparam int RDEPTH = 16;
  localparam int WDEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       flash_c, flash_sb;
  wire  [3:0] flash_dq;
  logic       miso = 1'b0;
  assign flash_dq[1] = miso;

  flash_spi_master_if bus ();

  flash_spi_master dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .flash_c(flash_c), .flash_sb(flash_sb), .flash_dq(flash_dq)
  );

  typedef struct { logic [7:0] op; int nw; int nr; } cmd_t;

  int          errors = 0, checks = 0;
  cmd_t        exp_cmd[$];
  logic [7:0]  exp_wdata[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  wq[$];
  logic [7:0]  status_seq[$];
  logic [7:0]  flash_mem [int];
  logic [7:0]  rx_bytes[$];
  logic [7:0]  cur_byte, cur_status;
  int          rise_cnt = 0, cyc = 0, last_rise = -1000, poll_cnt = 0;
  bit          mon_armed = 0, abort_cmd = 0, gap_skip = 1, pop_en = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endfunction

  function automatic logic [7:0] mem_rd(int a);
    if (flash_mem.exists(a)) return flash_mem[a];
    return 8'((a * 37 + 5) & 255);
  endfunction

  // Flash output bit for rising edge number k of the current select
  function automatic logic out_bit(int k);
    logic [7:0] op, b;
    int hdr, j;
    if (rx_bytes.size() == 0) return 1'b0;
    op  = rx_bytes[0];
    hdr = (op == 8'h03) ? 4 : (op == 8'h70) ? 1 : 1000;
    if (k < 8 * hdr) return 1'b0;
    j = k / 8 - hdr;
    if (op == 8'h70) b = cur_status;
    else b = mem_rd(int'({rx_bytes[1], rx_bytes[2], rx_bytes[3]}) + j);
    return b[7 - (k % 8)];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge flash_sb) begin
    if (mon_armed && !gap_skip) check("cs_gap_min", 32'((cyc - last_rise) >= 8), 32'd1);
    gap_skip = 0;
    rise_cnt = 0;
    rx_bytes.delete();
    miso = 1'b0;
  end

  always @(posedge flash_c) if (!flash_sb) begin
    cur_byte = {cur_byte[6:0], flash_dq[0]};
    rise_cnt++;
    if (rise_cnt % 8 == 0) begin
      rx_bytes.push_back(cur_byte);
      if (rise_cnt == 8 && cur_byte == 8'h70)
        cur_status = (status_seq.size() != 0) ? status_seq.pop_front() : 8'h80;
    end
  end

  always @(negedge flash_c) if (!flash_sb) miso = out_bit(rise_cnt);

  // Command monitor: compare each completed select against the scoreboard
  always @(posedge flash_sb) if (mon_armed) begin
    cmd_t e;
    int   mism;
    if (abort_cmd) begin
      abort_cmd = 0;
      gap_skip  = 1;
      if (exp_cmd.size() != 0) begin
        e = exp_cmd.pop_front();
        for (int i = 0; i < e.nw; i++) void'(exp_wdata.pop_front());
      end
    end else if (exp_cmd.size() == 0) begin
      check("unexpected_cmd", 32'(rise_cnt), 32'd0);
    end else begin
      e = exp_cmd.pop_front();
      last_rise = cyc;
      check("opcode", (rx_bytes.size() != 0) ? 32'(rx_bytes[0]) : 32'hdead, 32'(e.op));
      check("rising_edges", 32'(rise_cnt), 32'(8 * (1 + e.nw + e.nr)));
      mism = 0;
      for (int i = 0; i < e.nw; i++) begin
        logic [7:0] w;
        w = exp_wdata.pop_front();
        if (rx_bytes.size() <= i + 1 || rx_bytes[i + 1] !== w) mism++;
      end
      check("write_payload_mismatches", 32'(mism), 32'd0);
      if (rx_bytes.size() != 0 && rx_bytes[0] == 8'h70) poll_cnt++;
    end
  end

  // Read-side monitor: random pops, each popped head compared to the scoreboard
  initial begin
    bus.read_buffer_read = 1'b0;
    forever begin
      @(negedge clk);
      bus.read_buffer_read = 1'b0;
      if (pop_en && reset_n) begin
        if (!bus.read_buffer_empty) begin
          if ($urandom_range(0, 1) == 1) begin
            if (exp_rd.size() == 0) check("read_extra", 32'(bus.read_buffer_q), 32'h100);
            else check("read_data", 32'(bus.read_buffer_q), 32'(exp_rd.pop_front()));
            bus.read_buffer_read = 1'b1;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          bus.read_buffer_read = 1'b1;
        end
      end
    end
  end

  task automatic push_w(input logic [7:0] d);
    @(negedge clk);
    bus.write_buffer_data  = d;
    bus.write_buffer_write = 1'b1;
    @(negedge clk);
    bus.write_buffer_write = 1'b0;
  endtask

  // Scoreboard entry for a command whose write bytes are wq; pushes all but the last 'late'
  task automatic load(input logic [7:0] op, input int nr, input int late);
    int np;
    exp_cmd.push_back('{op: op, nw: wq.size(), nr: nr});
    foreach (wq[i]) exp_wdata.push_back(wq[i]);
`ifdef FLASH_POLL_EN
    if (op == 8'h02 || op == 8'h20 || op == 8'hD8) begin
      np = 1;
      for (int i = 0; i < status_seq.size() && !status_seq[i][7]; i++) np++;
      for (int i = 0; i < np; i++) exp_cmd.push_back('{op: 8'h70, nw: 0, nr: 1});
    end
`else
    np = 0;
`endif
    for (int i = 0; i < wq.size() - late; i++) push_w(wq[i]);
  endtask

  task automatic exec(input logic [7:0] op, input int nr);
    @(negedge clk);
    bus.instruction   = op;
    bus.bytes_to_read = 8'(nr);
    bus.execute       = 1'b1;
    @(negedge clk);
    bus.execute = 1'b0;
    check("busy_after_execute", 32'(bus.busy), 32'd1);
    check("sb_low_after_execute", 32'(flash_sb), 32'd0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin @(negedge clk); n++; end
    check("command_done", 32'(bus.busy), 32'd0);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_rd.size() != 0 && n < budget) begin @(negedge clk); n++; end
    check("read_drained", 32'(exp_rd.size()), 32'd0);
  endtask

  task automatic do_read(input int addr, input int nr);
    wq = '{8'(addr >> 16), 8'(addr >> 8), 8'(addr)};
    for (int i = 0; i < nr; i++) exp_rd.push_back(mem_rd(addr + i));
    load(8'h03, nr, 0);
    exec(8'h03, nr);
  endtask

  task automatic do_status(input logic [7:0] st);
    status_seq.push_back(st);
    exp_rd.push_back(st);
    wq.delete();
    load(8'h70, 1, 0);
    exec(8'h70, 1);
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_edges;
    bus.instruction = 8'h00; bus.execute = 1'b0; bus.bytes_to_read = 8'h00;
    bus.write_buffer_data = 8'h00; bus.write_buffer_write = 1'b0;
    reset_n = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_sb", 32'(flash_sb), 32'd1);
    check("reset_c", 32'(flash_c), 32'd0);
    check("reset_mosi", 32'(flash_dq[0]), 32'd0);
    check("reset_wp_hold", 32'(flash_dq[3:2]), 32'd3);
    check("reset_rempty", 32'(bus.read_buffer_empty), 32'd1);
    check("reset_wfull", 32'(bus.write_buffer_full), 32'd0);
    reset_n = 1'b1;
    mon_armed = 1;
    pop_en = 1;

    // Read 4 bytes at 0x000010
    flash_mem[16] = 8'h00; flash_mem[17] = 8'h00; flash_mem[18] = 8'h00; flash_mem[19] = 8'h02;
    do_read(32'h10, 4);
    wait_idle(5000); drain(2000);
    check("sb_high_after_read", 32'(flash_sb), 32'd1);

    // Page program 00,00,00,AB
    wq = '{8'h00, 8'h00, 8'h00, 8'hAB};
    load(8'h02, 0, 0); exec(8'h02, 0);
    wait_idle(5000);
    check("no_read_push_on_program", 32'(bus.read_buffer_empty), 32'd1);

    do_status(8'h80);
    wait_idle(5000); drain(2000);

    // Bytes pushed during the write phase join the same command
    wq.delete();
    for (int i = 0; i < 6; i++) wq.push_back(8'($urandom));
    load(8'h02, 0, 2); exec(8'h02, 0);
    push_w(wq[4]); push_w(wq[5]);
    wait_idle(5000);

    // Fill the write FIFO, then one dropped push
    wq.delete();
    for (int i = 0; i < WDEPTH; i++) wq.push_back(8'($urandom));
    load(8'h02, 0, 0);
    check("wfull_at_depth", 32'(bus.write_buffer_full), 32'd1);
    push_w(8'h5A);
    check("wfull_after_drop", 32'(bus.write_buffer_full), 32'd1);
    exec(8'h02, 0);
    wait_idle(20000);

    // Read FIFO backpressure: 20 bytes into a 16-deep FIFO with no pops
    pop_en = 0;
    do_read(32'h1234, 20);
    repeat (1500) @(negedge clk);
    stall_edges = rise_cnt;
    check("stall_busy", 32'(bus.busy), 32'd1);
    check("stall_clock_low", 32'(flash_c), 32'd0);
    check("stall_edges", 32'(stall_edges), 32'(8 * (4 + RDEPTH)));
    repeat (200) @(negedge clk);
    check("stall_holds", 32'(rise_cnt), 32'(stall_edges));
    pop_en = 1;
    wait_idle(5000); drain(2000);

    // Maximum read length
    do_read(int'($urandom_range(0, 32'hFFFF00)), 255);
    wait_idle(30000); drain(2000);

    // Randomized command mix
    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 2))
        0: do_read(int'($urandom_range(0, 32'hFFFFFF)), int'($urandom_range(0, 24)));
        1: do_status(8'($urandom));
        default: begin
          wq.delete();
          for (int i = 0; i < int'($urandom_range(0, 8)); i++) wq.push_back(8'($urandom));
          load(8'h02, 0, 0); exec(8'h02, 0);
        end
      endcase
      wait_idle(10000); drain(2000);
    end

    // Asynchronous reset during the second read byte
    pop_en = 0;
    do_read(int'($urandom_range(0, 32'hFFFF)), 8);
    for (int n = 0; n < 2000 && rise_cnt < 8 * 5 + 3; n++) @(negedge clk);
    check("reached_read_byte2", 32'(rise_cnt >= 8 * 5 + 3), 32'd1);
    abort_cmd = 1;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_sb", 32'(flash_sb), 32'd1);
    check("async_reset_c", 32'(flash_c), 32'd0);
    check("async_reset_busy", 32'(bus.busy), 32'd0);
    check("async_reset_rempty", 32'(bus.read_buffer_empty), 32'd1);
    check("async_reset_wfull", 32'(bus.write_buffer_full), 32'd0);
    exp_rd.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    pop_en = 1;
    do_status(8'h80);
    wait_idle(5000); drain(2000);

`ifdef FLASH_POLL_EN
    // Program followed by automatic flag-status polling: not ready, not ready, ready
    poll_cnt = 0;
    status_seq = '{8'h00, 8'h00, 8'h80};
    wq = '{8'h00, 8'h01, 8'h00, 8'h3C};
    load(8'h02, 0, 0); exec(8'h02, 0);
    wait_idle(10000);
    check("polls_before_idle", 32'(poll_cnt), 32'd3);
    check("poll_no_read_push", 32'(bus.read_buffer_empty), 32'd1);
`endif

    repeat (20) @(negedge clk);
    check("scoreboard_cmds_empty", 32'(exp_cmd.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
